// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 4x4 unsigned multiplier among NREQ requesters.
// Define MULT_SHARE_CNT_EN to add per-requester grant counters on port grant_cnt.

module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = {4'b0000, x} * {4'b0000, y};
endmodule

module mult_share_sched #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4-1:0]    req_x,
    input  logic [NREQ*4-1:0]    req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 busy
`ifdef MULT_SHARE_CNT_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  op_id;
    logic [3:0]      op_x;
    logic [3:0]      op_y;
    logic [7:0]      mult_o;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic            accept;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // Search starts at rr_ptr so the last winner becomes lowest priority.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high. Requesters hold valid and operands until their ready; the
    // response holds rsp_valid, rsp_id and rsp_data until rsp_ready.
    assign accept    = (state == IDLE) && win_found && !rst;
    assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
    assign busy      = (state != IDLE);

    main u_mult (
        .x (op_x),
        .y (op_y),
        .o (mult_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_x      <= '0;
            op_y      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_x   <= req_x[win_idx*4 +: 4];
                        op_y   <= req_y[win_idx*4 +: 4];
                        op_id  <= win_idx;
                        rr_ptr <= wrap_add(win_idx, 1);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_data  <= mult_o;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_SHARE_CNT_EN
    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win_idx == IDW'(i))
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end
`else
    // Counter feature compiled out; CNT_W has no effect in this build.
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (NREQ=4, CNT_W=2).
// Counter checks are included when MULT_SHARE_CNT_EN is defined.

module tb_mult_share_sched;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNT_W = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*4-1:0]    req_x;
    logic [NREQ*4-1:0]    req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_data;
    logic                 busy;
`ifdef MULT_SHARE_CNT_EN
    logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

    int total;
    int bad;

    mult_share_sched #(.NREQ(NREQ), .IDW(IDW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef MULT_SHARE_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        req_x     = 16'h1234;
        req_y     = 16'h5678;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: rsp_valid=%b busy=%b data=%0d id=%0d want 0 0 0 0",
                     rsp_valid, busy, rsp_data, rsp_id);
        end
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        rsp_ready = 1'b0;
        req_x     = 16'h0003;
        req_y     = 16'h0005;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_calc: rsp_valid=%b busy=%b want 0 1", rsp_valid, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'd15 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL single_rsp: valid=%b data=%0d id=%0d want 1 15 0",
                     rsp_valid, rsp_data, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int         grant_order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_q[$];
        logic [1:0] id_q[$];
        logic [3:0] exp_oh;
        logic [7:0] d_e;
        logic [1:0] i_e;
        int         grants = 0;
        int         rsps   = 0;
        int         cycles = 0;
        apply_reset();
        // slices: 3*4=12, 9*15=135, 15*15=225, 7*11=77
        exp_q = '{8'd12, 8'd135, 8'd225, 8'd77, 8'd12};
        id_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_x     = {4'd7, 4'd15, 4'd9, 4'd3};
        req_y     = {4'd11, 4'd15, 4'd15, 4'd4};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        while (rsps < 5 && cycles < 60) begin
            #1;
            if (|req_ready) begin
                exp_oh = 4'b0001 << grant_order[grants < 5 ? grants : 4];
                total++;
                if (grants >= 5 || req_ready !== exp_oh) begin
                    bad++;
                    $display("FAIL rr_grant: grant #%0d got %b want %b", grants, req_ready, exp_oh);
                end
                grants++;
            end
            if (rsp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rr_extra_rsp: data=%0d id=%0d want none", rsp_data, rsp_id);
                end else begin
                    d_e = exp_q.pop_front();
                    i_e = id_q.pop_front();
                    if (rsp_data !== d_e || rsp_id !== i_e) begin
                        bad++;
                        $display("FAIL rr_rsp: data=%0d id=%0d want %0d %0d", rsp_data, rsp_id, d_e, i_e);
                    end
                end
                rsps++;
            end
            @(negedge clk);
            if (grants >= 5) req_valid = '0;
            cycles++;
        end
        req_valid = '0;
        total++;
        if (rsps != 5 || grants != 5) begin
            bad++;
            $display("FAIL rr_count: grants=%0d rsps=%0d want 5 5", grants, rsps);
        end
    endtask

    task automatic test_backpressure();
        int cycles = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_x     = 16'hF000;
        req_y     = 16'hF000;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0001;
        req_x     = 16'hF00A;
        req_y     = 16'hF00B;
        while (!rsp_valid && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL bp_timeout: rsp_valid=%b want 1", rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd225 || rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%0d id=%0d ready=%b want 1 225 3 0000",
                         c, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_release: valid=%b busy=%b ready=%b want 0 0 0001",
                     rsp_valid, busy, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_exhaustive();
        logic [3:0] xv;
        logic [3:0] yv;
        logic [7:0] prod;
        int         errs = 0;
        rsp_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                xv   = x[3:0];
                yv   = y[3:0];
                prod = 8'(x * y);
                @(negedge clk);
                req_x     = {4'd0, xv, 4'd0, 4'd0};
                req_y     = {4'd0, yv, 4'd0, 4'd0};
                req_valid = 4'b0100;
                #1;
                total++;
                if (req_ready !== 4'b0100) begin
                    bad++;
                    errs++;
                    if (errs < 8) $display("FAIL exh_grant: x=%0d y=%0d got %b want 0100", x, y, req_ready);
                end
                @(negedge clk);
                req_valid = '0;
                @(negedge clk);
                #1;
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== prod || rsp_id !== 2'd2) begin
                    bad++;
                    errs++;
                    if (errs < 8) $display("FAIL exh_rsp: x=%0d y=%0d valid=%b data=%0d id=%0d want 1 %0d 2",
                                           x, y, rsp_valid, rsp_data, rsp_id, prod);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b0;
        // in CALC: accept requester 1 so rr_ptr moves to 2 first
        @(negedge clk);
        req_x     = 16'h0050;
        req_y     = 16'h0060;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        total++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_calc_pre: busy=%b valid=%b want 1 0", busy, rsp_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_calc: valid=%b busy=%b ready=%b want 0 0 0000", rsp_valid, busy, req_ready);
        end
        rst       = 1'b0;
        req_x     = 16'h0009;
        req_y     = 16'h0007;
        req_valid = 4'hF;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rst_calc_ptr: got %b want 0001", req_ready);
        end
        // in RESP: requester 0 accepted above, hold the response with rsp_ready=0
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'd63) begin
            bad++;
            $display("FAIL rst_resp_pre: valid=%b data=%0d want 1 63", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL rst_resp: valid=%b busy=%b data=%0d id=%0d want 0 0 0 0",
                     rsp_valid, busy, rsp_data, rsp_id);
        end
        rst       = 1'b0;
        req_valid = 4'hF;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rst_resp_ptr: got %b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

`ifdef MULT_SHARE_CNT_EN
    task automatic test_grant_counter();
        apply_reset();
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            req_x     = 16'h0020;
            req_y     = 16'h0030;
            req_valid = 4'b0010;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        total++;
        if (grant_cnt !== 8'b0000_0100) begin
            bad++;
            $display("FAIL grant_cnt: got %b want 00000100", grant_cnt);
        end
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_exhaustive();
        test_reset_mid_op();
`ifdef MULT_SHARE_CNT_EN
        test_grant_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
